// File: rtl/sbus_sram_arbiter.sv
// Shares one single-port synchronous SRAM among N_CH request channels.
// Responses are routed back in acceptance order through a RD_LAT-deep tag pipeline.
module sbus_sram_arbiter #(
    parameter int N_CH   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1,
    parameter int RR_EN  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_CH-1:0]               ch_req_valid,
    output logic [N_CH-1:0]               ch_req_ready,
    input  logic [N_CH*(DATA_W/8)-1:0]    ch_req_we,
    input  logic [N_CH*ADDR_W-1:0]        ch_req_addr,
    input  logic [N_CH*DATA_W-1:0]        ch_req_wdata,
    output logic [N_CH-1:0]               ch_resp_valid,
    output logic [DATA_W-1:0]             ch_resp_rdata,
    output logic                          sram_en,
    output logic [DATA_W/8-1:0]           sram_we,
    output logic [ADDR_W-1:0]             sram_addr,
    output logic [DATA_W-1:0]             sram_wdata,
    input  logic [DATA_W-1:0]             sram_rdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [IDX_W-1:0]  last_grant_q;
    logic [IDX_W-1:0]  last_grant_d;
    logic              grant_any;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  cand;

    logic [RD_LAT-1:0] tag_vld_q;
    logic [IDX_W-1:0]  tag_idx_q [RD_LAT];
    logic              resp_vld;

    // Grant selection; reset suppresses any grant so nothing is accepted while rst is high.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (!rst) begin
            if (RR_EN != 0) begin
                for (int k = 1; k <= N_CH; k++) begin
                    cand = IDX_W'((int'(last_grant_q) + k) % N_CH);
                    if (!grant_any && ch_req_valid[cand]) begin
                        grant_any = 1'b1;
                        grant_idx = cand;
                    end
                end
            end else begin
                for (int k = 0; k < N_CH; k++) begin
                    if (!grant_any && ch_req_valid[k]) begin
                        grant_any = 1'b1;
                        grant_idx = IDX_W'(k);
                    end
                end
            end
        end
    end

    assign last_grant_d = grant_any ? grant_idx : last_grant_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= IDX_W'(N_CH - 1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        sram_en    = grant_any;
        sram_we    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (grant_any) begin
            sram_we    = ch_req_we[grant_idx*BE_W +: BE_W];
            sram_addr  = ch_req_addr[grant_idx*ADDR_W +: ADDR_W];
            sram_wdata = ch_req_wdata[grant_idx*DATA_W +: DATA_W];
        end
    end

    // Tag pipeline: stage 0 captures the grant, later stages shift every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld_q[0] <= 1'b0;
        end else begin
            tag_vld_q[0] <= grant_any;
        end
        tag_idx_q[0] <= grant_idx;
    end

    for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_tag_stage
        always_ff @(posedge clk) begin
            if (rst) begin
                tag_vld_q[gi] <= 1'b0;
            end else begin
                tag_vld_q[gi] <= tag_vld_q[gi-1];
            end
            tag_idx_q[gi] <= tag_idx_q[gi-1];
        end
    end

    // A response is suppressed while rst is high even if the last stage still holds a tag.
    assign resp_vld      = tag_vld_q[RD_LAT-1] && !rst;
    assign ch_resp_rdata = resp_vld ? sram_rdata : '0;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
        assign ch_req_ready[gi]  = grant_any && (grant_idx == IDX_W'(gi));
        assign ch_resp_valid[gi] = resp_vld && (tag_idx_q[RD_LAT-1] == IDX_W'(gi));
    end

endmodule

// File: tb/tb_sbus_sram_arbiter.sv
// Directed bench: three arbiter instances (round-robin/RD_LAT=1, fixed-priority/RD_LAT=1,
// round-robin/RD_LAT=3) driven by shared stimulus, each with its own SRAM model.
module tb_sbus_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  valid;
    logic [3:0]  be0, be1;
    logic [31:0] a0, a1, w0, w1;

    logic [1:0]  ready  [3];
    logic [1:0]  rvalid [3];
    logic [31:0] rdata  [3];
    logic        en     [3];
    logic [3:0]  we     [3];
    logic [31:0] addr   [3];
    logic [31:0] wdata  [3];
    logic [31:0] srd    [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int RL = (gi == 2) ? 3 : 1;
        localparam int RR = (gi == 1) ? 0 : 1;

        logic [31:0] mem    [2048];
        logic [31:0] pipe_q [4];

        sbus_sram_arbiter #(
            .N_CH(2), .ADDR_W(32), .DATA_W(32), .RD_LAT(RL), .RR_EN(RR)
        ) dut (
            .clk          (clk),
            .rst          (rst),
            .ch_req_valid (valid),
            .ch_req_ready (ready[gi]),
            .ch_req_we    ({be1, be0}),
            .ch_req_addr  ({a1, a0}),
            .ch_req_wdata ({w1, w0}),
            .ch_resp_valid(rvalid[gi]),
            .ch_resp_rdata(rdata[gi]),
            .sram_en      (en[gi]),
            .sram_we      (we[gi]),
            .sram_addr    (addr[gi]),
            .sram_wdata   (wdata[gi]),
            .sram_rdata   (srd[gi])
        );

        // SRAM model: read data appears RL cycles after the enable.
        always @(posedge clk) begin
            if (rst) begin
                mem[0]      <= 32'h0000_AAA0;
                mem[1]      <= 32'h0000_AAA4;
                mem[2]      <= 32'h0000_AAA8;
                mem[8]      <= 32'hCAFE_0000;
                mem[11'h400] <= 32'hDEAD_BEEF;
            end else if (en[gi] && we[gi] != 4'b0) begin
                for (int b = 0; b < 4; b++)
                    if (we[gi][b]) mem[addr[gi][12:2]][b*8 +: 8] <= wdata[gi][b*8 +: 8];
            end
            pipe_q[0] <= (en[gi] && we[gi] == 4'b0) ? mem[addr[gi][12:2]] : 32'h0;
            for (int k = 1; k < 4; k++) pipe_q[k] <= pipe_q[k-1];
        end
        assign srd[gi] = pipe_q[RL-1];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        tick();
        rst   = 1'b1;
        valid = 2'b00;
        be0 = 4'b0; be1 = 4'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] exp_g;
        rst = 1'b1; valid = 2'b11;
        be0 = 4'b0; be1 = 4'b0;
        a0 = 32'h1000; a1 = 32'h4; w0 = 32'h0; w1 = 32'h0;
        tick(); tick(); #1;

        // Reset state while both channels request
        chk("rst_ready",  ready[0],  2'b00);
        chk("rst_en",     en[0],     1'b0);
        chk("rst_addr",   addr[0],   32'h0);
        chk("rst_rvalid", rvalid[0], 2'b00);
        chk("rst_rdata",  rdata[0],  32'h0);
        chk("rst_ready_l3", ready[2], 2'b00);
        $display("txn reset: ready=%b en=%b", ready[0], en[0]);

        // Single read from ch0
        tick();
        rst = 1'b0; valid = 2'b01; a0 = 32'h1000;
        #1;
        chk("rd_ready", ready[0], 2'b01);
        chk("rd_en",    en[0],    1'b1);
        chk("rd_addr",  addr[0],  32'h1000);
        $display("txn single read grant: ready=%b addr=%h", ready[0], addr[0]);
        tick();
        valid = 2'b00;
        #1;
        chk("rd_rvalid", rvalid[0], 2'b01);
        chk("rd_rdata",  rdata[0],  32'hDEAD_BEEF);
        $display("txn single read resp: rvalid=%b rdata=%h", rvalid[0], rdata[0]);

        // Contention: RR alternates, fixed priority sticks with ch0
        do_reset();
        a0 = 32'h0; a1 = 32'h4;
        for (int k = 0; k < 8; k++) begin
            valid = (k < 6) ? 2'b11 : ((k == 6) ? 2'b10 : 2'b00);
            #1;
            if (k < 6) begin
                exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
                chk("rr_grant", ready[0], exp_g);
                chk("fp_grant", ready[1], 2'b01);
            end
            if (k == 6) chk("fp_ch1_after_drop", ready[1], 2'b10);
            if (k >= 1 && k <= 6) begin
                exp_g = ((k - 1) % 2 == 0) ? 2'b01 : 2'b10;
                chk("rr_resp_valid", rvalid[0], exp_g);
                chk("rr_resp_rdata", rdata[0], (exp_g == 2'b01) ? 32'h0000_AAA0 : 32'h0000_AAA4);
            end
            $display("txn contention k=%0d: rr_ready=%b fp_ready=%b rr_rvalid=%b rr_rdata=%h",
                     k, ready[0], ready[1], rvalid[0], rdata[0]);
            tick();
        end

        // ch1 write then read of the same word
        do_reset();
        valid = 2'b10; be1 = 4'b0011; a1 = 32'h20; w1 = 32'h1234_5678;
        #1;
        chk("wr_ready", ready[0], 2'b10);
        chk("wr_en",    en[0],    1'b1);
        chk("wr_we",    we[0],    4'b0011);
        chk("wr_addr",  addr[0],  32'h20);
        chk("wr_wdata", wdata[0], 32'h1234_5678);
        $display("txn write: we=%b addr=%h wdata=%h", we[0], addr[0], wdata[0]);
        tick();
        be1 = 4'b0000;
        #1;
        chk("wr_ack",     rvalid[0], 2'b10);
        chk("rdbk_ready", ready[0],  2'b10);
        chk("rdbk_we",    we[0],     4'b0000);
        $display("txn write ack / readback grant: rvalid=%b ready=%b", rvalid[0], ready[0]);
        tick();
        valid = 2'b00;
        #1;
        chk("rdbk_rvalid", rvalid[0], 2'b10);
        chk("rdbk_rdata",  rdata[0],  32'hCAFE_5678);
        $display("txn readback: rvalid=%b rdata=%h", rvalid[0], rdata[0]);

        // Latency sweep on the RD_LAT=3 instance
        do_reset();
        for (int k = 0; k < 7; k++) begin
            valid = (k < 3) ? 2'b01 : 2'b00;
            a0 = 32'(k * 4);
            #1;
            if (k < 3) chk("lat_grant", ready[2], 2'b01);
            chk("lat_rvalid", rvalid[2], (k >= 3 && k <= 5) ? 2'b01 : 2'b00);
            if (k >= 3 && k <= 5) chk("lat_rdata", rdata[2], 32'h0000_AAA0 + 32'((k - 3) * 4));
            $display("txn latency k=%0d: ready=%b rvalid=%b rdata=%h", k, ready[2], rvalid[2], rdata[2]);
            tick();
        end

        // Reset with two reads in flight on the RD_LAT=3 instance
        do_reset();
        for (int k = 0; k < 8; k++) begin
            rst   = (k == 3 || k == 4);
            valid = (k < 2) ? 2'b01 : ((k == 5) ? 2'b11 : 2'b00);
            a0 = 32'(k * 4);
            #1;
            if (k < 2) chk("mf_grant", ready[2], 2'b01);
            if (k >= 3) chk("mf_no_resp", rvalid[2], 2'b00);
            if (k == 5) chk("mf_first_grant", ready[2], 2'b01);
            $display("txn reset-midflight k=%0d: rst=%b ready=%b rvalid=%b", k, rst, ready[2], rvalid[2]);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sbus_sram_arbiter.md
Name: sbus_sram_arbiter

Overview:
- Shares one single-port synchronous SRAM among N_CH request channels, e.g. the instruction and data buses of the core.
- It is a generalised successor to the one-bus-per-SRAM bridge. It adds configurable channel count, data width and SRAM read latency, fixed-priority or round-robin arbitration, and in-order response routing through a tag pipeline.
- It sits between the core's bus masters and the SoC SRAM port.

Parameters:
- N_CH, 2: number of request channels (1..8).
- ADDR_W, 32: address width.
- DATA_W, 32: data width; must be a multiple of 8.
- RD_LAT, 1: cycles from the SRAM enable to valid sram_rdata (1..4).
- RR_EN, 1: 1 selects round-robin arbitration; 0 selects fixed priority, lowest index wins.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- ch_req_valid  in  N_CH  per-channel request valid.
- ch_req_ready  out  N_CH  per-channel grant; one-hot or zero.
- ch_req_we  in  N_CH*DATA_W/8  per-channel byte write enables; all zero means a read.
- ch_req_addr  in  N_CH*ADDR_W  per-channel address.
- ch_req_wdata  in  N_CH*DATA_W  per-channel write data.
- ch_resp_valid  out  N_CH  per-channel response strobe; one-hot or zero.
- ch_resp_rdata  out  DATA_W  shared response data, qualified by ch_resp_valid.
- sram_en  out  1  SRAM enable.
- sram_we  out  DATA_W/8  SRAM byte write enables.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_rdata  in  DATA_W  SRAM read data.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-high on rst.
- Handshake:
  - A request transfers in a cycle where ch_req_valid[i] and ch_req_ready[i] are both high.
  - ch_req_ready is combinational from ch_req_valid and the arbiter state.
  - Masters hold valid, we, addr and wdata stable until accepted.
- Grant:
  - At most one grant per cycle; a channel with valid low is never granted.
  - In the grant cycle: sram_en=1, and sram_we/addr/wdata are the granted channel's slice.
  - With no grant: sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0.
- Fixed priority (RR_EN=0): grant the lowest-index valid channel.
- Round robin (RR_EN=1):
  - Register last_grant.
  - Grant the first valid channel scanning last_grant+1, last_grant+2, … modulo N_CH.
  - last_grant updates only on a grant.
  - A continuously requesting channel waits at most N_CH-1 cycles.
- Tag pipeline:
  - RD_LAT-deep shift register of {valid, channel index}, advanced every cycle.
  - Stage 0 loads {1, granted index} on a grant and {0, x} otherwise.
- Response:
  - When the last stage is valid, ch_resp_valid[idx]=1 and ch_resp_rdata=sram_rdata, in that same cycle.
  - Otherwise ch_resp_valid=0 and ch_resp_rdata=0.
  - Net latency is RD_LAT cycles after acceptance.
- Writes:
  - Also produce exactly one response, an acknowledge, RD_LAT cycles later.
  - ch_resp_rdata carries sram_rdata unchanged.
  - Masters ignore ch_resp_rdata for writes.
- Ordering and flow control:
  - Responses return in acceptance order, both globally and per channel.
  - There is no response backpressure; masters must always accept responses.
  - Throughput is one request per cycle aggregate.
- Reset:
  - While rst=1: ch_req_ready=0, sram_en=0, all SRAM outputs 0, ch_resp_valid=0, ch_resp_rdata=0.
  - Reset clears the tag pipeline; responses in flight are dropped, never emitted after reset.
  - last_grant resets to N_CH-1, so channel 0 wins first.
- Boundary cases:
  - N_CH=1: the arbiter degenerates to a pass-through, ch_req_ready = ch_req_valid outside reset.
  - RD_LAT=1: a single tag stage.
  - A request accepted in the last cycle before rst asserts produces no response.
  - last_grant wraps from N_CH-1 to 0.

Test Plan:
- Single read: N_CH=2, RD_LAT=1, ch0 reads 0x1000 with SRAM returning 0xDEADBEEF.
  - Required: ready[0]=1 and sram_en=1, addr=0x1000 in cycle T.
  - Required: resp_valid=2'b01, rdata=0xDEADBEEF in T+1.
- Round-robin contention: RR_EN=1, both channels valid for 6 cycles.
  - Required: grants 0,1,0,1,0,1.
  - Required: responses 0,1,0,1,0,1 each delayed by RD_LAT=1.
- Fixed priority: RR_EN=0, both channels valid for 4 cycles.
  - Required: ch0 granted every cycle and ready[1] never asserted.
  - Required: ch1 granted the cycle after ch0 drops valid.
- Write then read: ch1 writes we=4'b0011, addr 0x20, wdata 0x12345678, then reads 0x20.
  - Required: sram_we=4'b0011 for the write, followed by a write-ack response.
  - Required: the read returns the model value with low half 0x5678.
- Latency sweep: RD_LAT=3, back-to-back reads from ch0 at 0x0, 0x4, 0x8.
  - Required: responses in cycles T+3, T+4, T+5, in order, carrying the model data.
- Reset mid-flight: RD_LAT=3, rst asserted 1 cycle after two accepted reads.
  - Required: no ch_resp_valid during or after reset.
  - Required: the first post-reset grant goes to ch0.
